// File: rtl/sm_addsub_serial_pkg.sv
// Shared definitions for the digit-serial sign-magnitude adder/subtractor.
// State encodings and sign encoding constants.
package sm_addsub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

endpackage

// File: rtl/sm_addsub_serial_rca.sv
// Purpose: N-bit ripple-carry adder, used as the D-bit digit slice.
// Latency: combinational.
// Backpressure: none (pure logic).
module rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/sm_addsub_serial.sv
// Purpose: digit-serial sign-magnitude add/sub, D magnitude bits per clock.
// Latency: N/D cycles, or 2*N/D when the difference must be re-negated.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module sm_addsub_serial
    import sm_addsub_serial_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         a_s,
    input  logic [N-1:0] a_m,
    input  logic         b_s,
    input  logic [N-1:0] b_m,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         s_s,
    output logic [N-1:0] s_m,
    output logic         ovf
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (N % D != 0) begin : g_bad_digit
        $error("sm_addsub_serial: N must be a multiple of D");
    end

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            a_s_q, eb_q, eff_sub_q;
    logic [N-1:0]    a_sh_q, b_sh_q, r_q;
    logic            in_ready_q, out_valid_q, s_s_q, ovf_q;

    logic            accept, last_dig;
    logic [D-1:0]    slice_a, slice_b, slice_s;
    logic            slice_co;
    logic [N-1:0]    dig_top, r_nxt;

    assign accept   = in_valid && in_ready_q && (state_q == ST_IDLE);
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    // PASS2 reuses the slice as an incrementer: ~R + 0 + carry.
    always_comb begin
        slice_a = a_sh_q[D-1:0];
        slice_b = eff_sub_q ? ~b_sh_q[D-1:0] : b_sh_q[D-1:0];
        if (state_q == ST_PASS2) begin
            slice_a = ~r_q[D-1:0];
            slice_b = '0;
        end
    end

    rca #(.N(D)) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Result digits enter at the top so after N/D shifts the LSB digit is at bit 0.
    always_comb begin
        dig_top            = '0;
        dig_top[N-1 -: D]  = slice_s;
        r_nxt              = (r_q >> D) | dig_top;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_nxt = ST_PASS1;
            ST_PASS1: if (last_dig) state_nxt = (eff_sub_q && !slice_co) ? ST_PASS2 : ST_DONE;
            ST_PASS2: if (last_dig) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_s_q       <= SIGN_POS;
            eb_q        <= SIGN_POS;
            eff_sub_q   <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s_s_q       <= SIGN_POS;
            ovf_q       <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == ST_IDLE);
            out_valid_q <= (state_nxt == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_s_q     <= a_s;
                        eb_q      <= b_s ^ sub;
                        eff_sub_q <= a_s ^ b_s ^ sub;
                        carry_q   <= a_s ^ b_s ^ sub;
                        a_sh_q    <= a_m;
                        b_sh_q    <= b_m;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                ST_PASS1: begin
                    a_sh_q  <= a_sh_q >> D;
                    b_sh_q  <= b_sh_q >> D;
                    r_q     <= r_nxt;
                    carry_q <= slice_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_dig) begin
                        cnt_q <= '0;
                        if (eff_sub_q && !slice_co) begin
                            s_s_q   <= eb_q;
                            ovf_q   <= 1'b0;
                            carry_q <= 1'b1;
                        end else begin
                            ovf_q <= eff_sub_q ? 1'b0 : slice_co;
                            s_s_q <= (r_nxt == '0) ? SIGN_POS : a_s_q;
                        end
                    end
                end
                ST_PASS2: begin
                    r_q     <= r_nxt;
                    carry_q <= slice_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_dig) begin
                        cnt_q <= '0;
                        if (r_nxt == '0) s_s_q <= SIGN_POS;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s_s       = s_s_q;
    assign s_m       = r_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_addsub_serial.sv
// Self-checking bench for sm_addsub_serial (N=8, D=4): directed table,
// handshake/reset sequences, and random ops against an arithmetic model.
module tb_sm_addsub_serial;

    localparam int N = 8;
    localparam int D = 4;
    localparam int NDIG = N / D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         a_s = 1'b0, b_s = 1'b0, sub = 1'b0;
    logic [N-1:0] a_m = '0, b_m = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         s_s;
    logic [N-1:0] s_m;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sm_addsub_serial #(.N(N), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_s       (a_s),
        .a_m       (a_m),
        .b_s       (b_s),
        .b_m       (b_m),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_s       (s_s),
        .s_m       (s_m),
        .ovf       (ovf)
    );

    typedef struct {
        logic         as;
        logic [N-1:0] am;
        logic         bs;
        logic [N-1:0] bm;
        logic         sb;
        logic         es;
        logic [N-1:0] em;
        logic         eovf;
        int           elat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: signed-magnitude arithmetic done with plain integers.
    function automatic vec_t model(input logic as, input logic [N-1:0] am,
                                   input logic bs, input logic [N-1:0] bm, input logic sb);
        vec_t v;
        int   va, vb, sum, mag;
        logic eb;
        v.as = as; v.am = am; v.bs = bs; v.bm = bm; v.sb = sb;
        eb  = bs ^ sb;
        va  = as ? -int'(am) : int'(am);
        vb  = eb ? -int'(bm) : int'(bm);
        sum = va + vb;
        mag = (sum < 0) ? -sum : sum;
        v.eovf = (mag >= (1 << N));
        v.em   = mag[N-1:0];
        v.es   = (sum < 0) && (v.em != 0);
        v.elat = (as != eb && bm > am) ? 2 * NDIG : NDIG;
        return v;
    endfunction

    task automatic accept(input vec_t v);
        @(negedge clk);
        a_s = v.as; a_m = v.am; b_s = v.bs; b_m = v.bm; sub = v.sb;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 0);
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input vec_t v, input int lat);
        chk({name, "_lat"}, lat, v.elat);
        chk({name, "_s_s"}, s_s, v.es);
        chk({name, "_s_m"}, s_m, v.em);
        chk({name, "_ovf"}, ovf, v.eovf);
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_vld_drop"}, out_valid, 0);
        chk({name, "_rdy_back"}, in_ready, 1);
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat;
        accept(v);
        wait_out(lat);
        check_result(name, v, lat);
        handshake(name);
    endtask

    initial begin
        vec_t v, nv;
        int   lat;

        vecs[0] = '{1'b0, 8'd5,   1'b0, 8'd3,   1'b0, 1'b0, 8'd8,   1'b0, 2};
        vecs[1] = '{1'b0, 8'd3,   1'b0, 8'd5,   1'b1, 1'b1, 8'd2,   1'b0, 4};
        vecs[2] = '{1'b0, 8'd200, 1'b0, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 2};
        vecs[3] = '{1'b1, 8'd100, 1'b0, 8'd100, 1'b1, 1'b1, 8'd200, 1'b0, 2};
        vecs[4] = '{1'b0, 8'd7,   1'b1, 8'd7,   1'b0, 1'b0, 8'd0,   1'b0, 2};
        vecs[5] = '{1'b1, 8'd0,   1'b1, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 2};
        vecs[6] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 8'd0,   1'b0, 2};

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s_m", s_m, 0);
        chk("rst_s_s", s_s, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held while a new op waits on in_valid.
        v  = vecs[0];
        nv = '{1'b0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2, 1'b0, 2};
        accept(v);
        wait_out(lat);
        check_result("bp", v, lat);
        @(negedge clk);
        a_s = nv.as; a_m = nv.am; b_s = nv.bs; b_m = nv.bm; sub = nv.sb;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_vld", out_valid, 1);
            chk("bp_hold_s_m", s_m, 8);
            chk("bp_hold_rdy", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_vld", out_valid, 0);
        chk("bp_hs_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_taken", in_ready, 0);
        wait_out(lat);
        check_result("bp_new", nv, lat);
        handshake("bp_new");

        // Asynchronous reset in the middle of the negate pass.
        accept(vecs[1]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_s_m", s_m, 0);
        chk("mid_rst_s_s", s_s, 0);
        chk("mid_rst_rdy", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy", in_ready, 1);
        run_op("post_rst", model(1'b0, 8'd9, 1'b0, 8'd4, 1'b1));

        for (int i = 0; i < 40; i++) begin
            v = model($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                      (i % 8 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                      $urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
